alu_op_issuer: RTL

//   Initiator for the MIPSALU port set (ALUCtl, A, B, ALUOut, Zero). Accepts R-type
//   ops (funct, rs value, rt value) over a valid/ready handshake, decodes funct to

---
 rtl/alu_op_issuer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issues MIPS R-type ops to a combinational MIPSALU.
// Decodes funct to ALUCtl, holds the operands for a settle window, captures
// ALUOut/Zero and returns them over a valid/ready handshake. One op in flight.
module alu_op_issuer #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  // op request
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  // MIPSALU port set
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  // result
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  // A settle time of zero still needs one edge to capture the ALU result.
  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned SET_W      = $clog2(SETTLE_EFF + 1);

  localparam logic [5:0] FUNCT_ADD = 6'd32;
  localparam logic [5:0] FUNCT_SUB = 6'd34;
  localparam logic [5:0] FUNCT_AND = 6'd36;
  localparam logic [5:0] FUNCT_OR  = 6'd37;
  localparam logic [5:0] FUNCT_NOR = 6'd39;
  localparam logic [5:0] FUNCT_SLT = 6'd42;

  localparam logic [3:0] CTL_AND = 4'd0;
  localparam logic [3:0] CTL_OR  = 4'd1;
  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_SUB = 4'd6;
  localparam logic [3:0] CTL_SLT = 4'd7;
  localparam logic [3:0] CTL_NOR = 4'd12;
  localparam logic [3:0] CTL_BAD = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [SET_W-1:0]   set_cnt_q,   set_cnt_d;
  logic               err_q,       err_d;
  logic               in_ready_q,  in_ready_d;
  logic [3:0]         alu_ctl_q,   alu_ctl_d;
  logic [WIDTH-1:0]   alu_a_q,     alu_a_d;
  logic [WIDTH-1:0]   alu_b_q,     alu_b_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic               out_zero_q,  out_zero_d;
  logic               out_err_q,   out_err_d;
  logic [CNT_W-1:0]   op_count_q,  op_count_d;

  logic [3:0]         dec_ctl_c;
  logic               dec_err_c;

  // Funct decode; unsupported functs map to an ALUCtl the ALU resolves to 0.
  always_comb begin
    dec_ctl_c = CTL_BAD;
    dec_err_c = 1'b0;
    unique case (in_funct)
      FUNCT_ADD: dec_ctl_c = CTL_ADD;
      FUNCT_SUB: dec_ctl_c = CTL_SUB;
      FUNCT_AND: dec_ctl_c = CTL_AND;
      FUNCT_OR:  dec_ctl_c = CTL_OR;
      FUNCT_NOR: dec_ctl_c = CTL_NOR;
      FUNCT_SLT: dec_ctl_c = CTL_SLT;
      default: begin
        dec_ctl_c = CTL_BAD;
        dec_err_c = 1'b1;
      end
    endcase
  end

  // Next-state and registered-output logic for IDLE -> SETTLE -> RESP.
  always_comb begin
    state_d     = state_q;
    set_cnt_d   = set_cnt_q;
    err_d       = err_q;
    alu_ctl_d   = alu_ctl_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;
    out_err_d   = out_err_q;
    op_count_d  = op_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          alu_ctl_d = dec_ctl_c;
          alu_a_d   = in_a;
          alu_b_d   = in_b;
          err_d     = dec_err_c;
          set_cnt_d = SET_W'(SETTLE_EFF);
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (set_cnt_q == SET_W'(1)) begin
          out_data_d  = alu_out;
          out_zero_d  = alu_zero;
          out_err_d   = err_q;
          out_valid_d = 1'b1;
          set_cnt_d   = '0;
          state_d     = S_RESP;
        end else begin
          set_cnt_d = set_cnt_q - SET_W'(1);
        end
      end
      S_RESP: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset discards any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      set_cnt_q   <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      alu_ctl_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      set_cnt_q   <= set_cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      alu_ctl_q   <= alu_ctl_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
      out_err_q   <= out_err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign alu_ctl   = alu_ctl_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;
  assign out_err   = out_err_q;
  assign op_count  = op_count_q;

endmodule
